// File: rtl/gnt_event_fifo.sv
// Grant-change event logger: detects per-channel grant toggles/rises and queues
// the 1-based channel IDs in a small FIFO, lowest channel first, one per cycle.
module gnt_event_fifo #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned EDGE_MODE  = 0,
  parameter int unsigned AF_LEVEL   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     gnt_vec,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [3:0]            rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  logic [NUM_CH-1:0] prev, pending, change, push_bit, pending_next;
  logic [3:0]        push_id, rd_data_next;
  logic              push, pop, overflow_next;
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [CW-1:0]     count_next;
  logic [3:0]        mem [DEPTH];

  // Event detection, lowest-index pending select and FIFO bookkeeping
  always_comb begin
    change   = (EDGE_MODE != 0) ? (gnt_vec & ~prev) : (gnt_vec ^ prev);
    push     = (pending != '0) && !full;
    pop      = rd_en && !empty;
    push_bit = '0;
    push_id  = '0;
    // Descending scan so the lowest set index wins
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_bit    = '0;
        push_bit[i] = 1'b1;
        push_id     = 4'(i + 1);
      end
    end
    if (!push) begin
      push_bit = '0;
    end
    pending_next  = (pending & ~push_bit) | change;
    overflow_next = overflow;
    if ((change & pending & ~push_bit) != '0) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end
    wr_ptr_next  = push ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_next  = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_next   = count + CW'(push) - CW'(pop);
    rd_data_next = pop ? mem[rd_ptr] : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= '0;
      pending     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      prev        <= gnt_vec;
      pending     <= pending_next;
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      count       <= count_next;
      rd_data     <= rd_data_next;
      rd_valid    <= pop;
      overflow    <= overflow_next;
      empty       <= (count_next == '0);
      full        <= (count_next == CW'(DEPTH));
      almost_full <= (32'(count_next) >= AF_LEVEL);
    end
  end

  // Storage needs no reset; stale entries are never read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_id;
    end
  end

endmodule

// File: tb/tb_gnt_event_fifo.sv
// Bench for gnt_event_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gnt_event_fifo;

  localparam int NCH   = 10;
  localparam int DL    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] gnt = '0;
  logic           rd_en = 1'b0, clr_ovf = 1'b0;
  logic [3:0]     rd_data;
  logic           rd_valid, empty, full, almost_full, overflow;
  logic [DL:0]    count;

  logic [7:0]     gnt1 = '0;
  logic           rd_en1 = 1'b0, clr1 = 1'b0;
  logic [3:0]     rd_data1;
  logic           rd_valid1, empty1, full1, af1, ovf1;
  logic [DL:0]    count1;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  gnt_event_fifo #(.NUM_CH(NCH), .DEPTH_LOG2(DL), .EDGE_MODE(0), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n), .gnt_vec(gnt), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overflow(overflow));

  gnt_event_fifo #(.EDGE_MODE(1)) dut_rise (
    .clk(clk), .rst_n(rst_n), .gnt_vec(gnt1), .rd_en(rd_en1), .clr_ovf(clr1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .empty(empty1), .full(full1),
    .almost_full(af1), .count(count1), .overflow(ovf1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: prev levels, pending set, FIFO as a queue of IDs
  logic [NCH-1:0] m_prev, m_pend;
  int             m_q[$];
  int             m_data;
  bit             m_valid, m_ovf;

  always @(posedge clk or negedge rst_n) begin : model
    logic [NCH-1:0] chg, pb;
    int id;
    if (!rst_n) begin
      m_prev = '0; m_pend = '0; m_q.delete();
      m_data = 0; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      chg = gnt ^ m_prev;
      id  = 0;
      pb  = '0;
      if (m_q.size() < DEPTH) begin
        for (int i = 0; i < NCH; i++)
          if (m_pend[i] && id == 0) id = i + 1;
      end
      if (id != 0) pb[id-1] = 1'b1;
      if (rd_en && m_q.size() > 0) begin
        m_data = m_q.pop_front(); m_valid = 1'b1;
      end else begin
        m_data = 0; m_valid = 1'b0;
      end
      if (id != 0) m_q.push_back(id);
      if ((chg & m_pend & ~pb) != '0) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_pend = (m_pend & ~pb) | chg;
      m_prev = gnt;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && cmp_on) begin
      chk("rd_data", int'(rd_data), m_data);
      chk("rd_valid", int'(rd_valid), int'(m_valid));
      chk("count", int'(count), m_q.size());
      chk("empty", int'(empty), int'(m_q.size() == 0));
      chk("full", int'(full), int'(m_q.size() == DEPTH));
      chk("almost_full", int'(almost_full), int'(m_q.size() >= AF));
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; gnt = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_rd_data"}, int'(rd_data), 0);
    chk({tag, "_rd_valid"}, int'(rd_valid), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_af"}, int'(almost_full), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
  endtask

  initial begin
    step(2);
    check_reset_outs("rst_hold");
    rst_n = 1'b1;
    cmp_on = 1'b1;
    step(1);
    check_reset_outs("rst_rel");

    // Rising-edge mode: rise then fall on channel 2 logs one event
    gnt1 = 8'h04; step(1);
    gnt1 = 8'h00; step(3);
    chk("rise_count", int'(count1), 1);
    rd_en1 = 1'b1; step(1); rd_en1 = 1'b0;
    chk("rise_data", int'(rd_data1), 3);
    chk("rise_valid", int'(rd_valid1), 1);
    step(3);
    chk("rise_count_after", int'(count1), 0);

    // Single toggle
    gnt = 10'h004; step(2);
    chk("single_count", int'(count), 1);
    rd_en = 1'b1; step(1); rd_en = 1'b0;
    chk("single_data", int'(rd_data), 3);
    chk("single_valid", int'(rd_valid), 1);
    chk("single_empty", int'(empty), 1);

    // Simultaneous changes on channels 0 and 7
    do_reset();
    gnt = 10'h081; step(3);
    chk("simul_count", int'(count), 2);
    rd_en = 1'b1; step(1);
    chk("simul_first", int'(rd_data), 1);
    step(1); rd_en = 1'b0;
    chk("simul_second", int'(rd_data), 8);

    // Fill with nine simultaneous events, ninth waits in pending
    do_reset();
    gnt = 10'h1FF; step(10);
    chk("fill_count", int'(count), 8);
    chk("fill_full", int'(full), 1);
    chk("fill_af", int'(almost_full), 1);
    rd_en = 1'b1; step(1); rd_en = 1'b0;
    chk("fill_pop_data", int'(rd_data), 1);
    chk("fill_pop_count", int'(count), 7);
    step(1);
    chk("fill_refill_count", int'(count), 8);

    // Overflow: channel 0 toggled twice while full
    gnt = 10'h1FE; step(1);
    gnt = 10'h1FF; step(1);
    chk("ovf_set", int'(overflow), 1);
    clr_ovf = 1'b1; step(1); clr_ovf = 1'b0;
    chk("ovf_clr", int'(overflow), 0);

    // Empty read, then wrap with push/pop pairs
    do_reset();
    rd_en = 1'b1; step(1); rd_en = 1'b0;
    chk("empty_rd_valid", int'(rd_valid), 0);
    chk("empty_rd_data", int'(rd_data), 0);
    for (int k = 0; k < 20; k++) begin
      gnt[k % NCH] = ~gnt[k % NCH];
      step(2);
      chk("wrap_count", int'(count), 1);
      rd_en = 1'b1; step(1); rd_en = 1'b0;
      chk("wrap_data", int'(rd_data), (k % NCH) + 1);
    end

    // Randomized traffic with a mid-stream asynchronous reset
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 99) < 70) gnt[$urandom_range(0, NCH - 1)] ^= 1'b1;
        else gnt ^= NCH'($urandom);
      end
      rd_en   = ($urandom_range(0, 99) < (((it / 100) % 2 == 1) ? 15 : 60));
      clr_ovf = ($urandom_range(0, 19) == 0);
      if (it == 450) begin
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check_reset_outs("async_rst");
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end

    rd_en = 1'b0; clr_ovf = 1'b0;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
